// File: rtl/song_sequencer_if.sv
// Song ROM bus between the sequencer (master) and a synchronous song ROM (slave).
// Read latency is one cycle: data is registered from the address of the previous cycle.
interface song_sequencer_if #(
  parameter int SONG_AW = 6
);
  logic [SONG_AW+2:0] rom_addr;
  logic [8:0]         rom_data;

  modport master (output rom_addr, input  rom_data);
  modport slave  (input  rom_addr, output rom_data);
endinterface

// File: rtl/song_sequencer.sv
// Steps through a stored song, timing each note in beat ticks. In auto mode it
// plays back-to-back; in learn mode it shows a hint and waits for the matching key.
module song_sequencer #(
  parameter int TICK_DIV = 12_500_000,
  parameter int SONG_AW  = 6
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic                learn,
  input  logic [2:0]          song_id,
  song_sequencer_if.master    rom,
  input  logic                key_valid,
  input  logic [4:0]          key_note,
  output logic [4:0]          note_out,
  output logic                note_en,
  output logic [4:0]          hint_note,
  output logic                busy,
  output logic                done,
  output logic [7:0]          miss_cnt
);

  localparam int                TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SONG_AW-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_ROM, S_PLAY, S_WAIT_KEY
  } state_t;

  state_t               state, state_nx;
  logic [2:0]           song_q;
  logic                 learn_q;
  logic [SONG_AW-1:0]   idx;
  logic [3:0]           dur_q;
  logic [3:0]           beat_cnt;
  logic [TW-1:0]        tick_cnt;

  logic [4:0] rom_note;
  logic [3:0] rom_dur;
  logic       play_end;
  logic       key_hit;

  assign rom_note     = rom.rom_data[8:4];
  assign rom_dur      = rom.rom_data[3:0];
  assign rom.rom_addr = {song_q, idx};
  // dur_q is never 0 in PLAY: a zero duration ends the song before PLAY is entered.
  assign play_end     = (state == S_PLAY) && (tick_cnt == TICK_LAST) &&
                        (beat_cnt == dur_q - 4'd1);
  assign key_hit      = key_valid && (key_note == hint_note);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge sys_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nx unassigned (no latch).
    state_nx = state;
    if (stop) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (start) state_nx = S_FETCH;
        S_FETCH:    state_nx = S_WAIT_ROM;
        S_WAIT_ROM: begin
          if (rom_dur == 4'd0)                      state_nx = S_IDLE;
          else if (!learn_q || rom_note == 5'd0)    state_nx = S_PLAY;
          else                                      state_nx = S_WAIT_KEY;
        end
        S_PLAY:     if (play_end) state_nx = (idx == IDX_LAST) ? S_IDLE : S_FETCH;
        S_WAIT_KEY: if (key_hit) state_nx = S_PLAY;
        default:    state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state != S_IDLE);
    note_en = (state == S_PLAY) && (note_out != 5'd0);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      song_q    <= '0;
      learn_q   <= 1'b0;
      idx       <= '0;
      dur_q     <= '0;
      beat_cnt  <= '0;
      tick_cnt  <= '0;
      note_out  <= '0;
      hint_note <= '0;
      done      <= 1'b0;
      miss_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        hint_note <= '0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            song_q   <= song_id;
            learn_q  <= learn;
            idx      <= '0;
            miss_cnt <= '0;
          end
          S_WAIT_ROM: begin
            dur_q    <= rom_dur;
            beat_cnt <= '0;
            tick_cnt <= '0;
            if (rom_dur == 4'd0)                   done      <= 1'b1;
            else if (!learn_q || rom_note == 5'd0) note_out  <= rom_note;
            else                                   hint_note <= rom_note;
          end
          S_PLAY: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              beat_cnt <= beat_cnt + 4'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
            if (play_end) begin
              hint_note <= '0;
              if (idx == IDX_LAST) done <= 1'b1;
              else                 idx  <= idx + 1'b1;
            end
          end
          S_WAIT_KEY: if (key_valid) begin
            if (key_hit) begin
              note_out <= key_note;
              beat_cnt <= '0;
              tick_cnt <= '0;
            end else if (miss_cnt != 8'hFF) begin
              miss_cnt <= miss_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: stimulus queues expected note/done events,
// a negedge monitor measures what the DUT plays and compares in order.
module tb_song_sequencer;

  localparam int TICK_DIV = 4;
  localparam int SONG_AW  = 2;

  logic       sys_clk = 1'b0;
  logic       rst, start, stop, learn, key_valid;
  logic [2:0] song_id;
  logic [4:0] key_note, note_out, hint_note;
  logic       note_en, busy, done;
  logic [7:0] miss_cnt;

  song_sequencer_if #(.SONG_AW(SONG_AW)) bus ();

  song_sequencer #(.TICK_DIV(TICK_DIV), .SONG_AW(SONG_AW)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .learn     (learn),
    .song_id   (song_id),
    .rom       (bus),
    .key_valid (key_valid),
    .key_note  (key_note),
    .note_out  (note_out),
    .note_en   (note_en),
    .hint_note (hint_note),
    .busy      (busy),
    .done      (done),
    .miss_cnt  (miss_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Song ROM model: one-cycle registered read.
  logic [8:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 9'h000;
    mem[4]  = 9'h152; mem[5]  = 9'h131; mem[6]  = 9'h000;               // song 1
    mem[8]  = 9'h003; mem[9]  = 9'h121; mem[10] = 9'h000;               // song 2: rest first
    mem[12] = 9'h0A1; mem[13] = 9'h0B1; mem[14] = 9'h0C1; mem[15] = 9'h0D1; // song 3: no end
    mem[16] = 9'h1F1;
  end
  always @(posedge sys_clk) bus.rom_data <= mem[bus.rom_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef enum int {EV_NOTE, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       note;
    int       len;
    int       addr;
    int       gap;   // -1: don't care
  } ev_t;

  ev_t sb[$];

  task automatic push_note(input int note, input int len, input int addr, input int gap);
    ev_t e;
    e.kind = EV_NOTE; e.note = note; e.len = len; e.addr = addr; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.kind = EV_DONE; e.note = 0; e.len = 0; e.addr = 0; e.gap = -1;
    sb.push_back(e);
  endtask

  task automatic sb_compare(input ev_t got);
    ev_t exp;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected: got kind %0d note %0h len %0d, expected no event",
               got.kind, got.note, got.len);
      return;
    end
    exp = sb.pop_front();
    check("ev_kind", got.kind, exp.kind);
    if (exp.kind == EV_NOTE) begin
      check("ev_note", got.note, exp.note);
      check("ev_len",  got.len,  exp.len);
      check("ev_addr", got.addr, exp.addr);
      if (exp.gap >= 0) check("ev_gap", got.gap, exp.gap);
    end
  endtask

  // Monitor: mid-cycle sampling of note runs and done pulses.
  bit   in_run = 0, first = 1;
  int   low_cnt = 0;
  ev_t  run;
  always @(negedge sys_clk) begin
    if (rst) begin
      in_run = 0; first = 1; low_cnt = 0;
    end else begin
      if (note_en) begin
        if (!in_run) begin
          in_run   = 1;
          run.kind = EV_NOTE;
          run.note = int'(note_out);
          run.len  = 1;
          run.addr = int'(bus.rom_addr);
          run.gap  = first ? -1 : low_cnt;
          first    = 0;
        end else begin
          run.len++;
          if (int'(note_out) != run.note) check("note_stable", note_out, run.note);
        end
      end else begin
        if (in_run) begin
          in_run  = 0;
          low_cnt = 0;
          sb_compare(run);
        end
        if (busy) low_cnt++;
      end
      if (done) begin
        ev_t d;
        d.kind = EV_DONE; d.note = 0; d.len = 0; d.addr = 0; d.gap = -1;
        sb_compare(d);
        check("done_busy_low", busy, 0);
      end
      if (!busy) first = 1;
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse_start(input logic [2:0] id, input logic lrn);
    song_id = id; learn = lrn; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input logic [4:0] n);
    key_note = n; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, busy, 0);
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw_en;
    rst = 1'b1; start = 1'b0; stop = 1'b0; learn = 1'b0; song_id = '0;
    key_valid = 1'b0; key_note = '0;
    repeat (3) tick();
    check("rst_busy",     busy,         0);
    check("rst_note_en",  note_en,      0);
    check("rst_note_out", note_out,     0);
    check("rst_hint",     hint_note,    0);
    check("rst_miss",     miss_cnt,     0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_done",     done,         0);
    rst = 1'b0;
    tick();

    // Auto play of song 1.
    push_note(5'h15, 8, 4, -1);
    push_note(5'h13, 4, 5, 2);
    push_done();
    pulse_start(3'd1, 1'b0);
    check("auto_rom_addr0", bus.rom_addr, 4);
    check("auto_busy",      busy,         1);
    tick();
    check("auto_en_edge1",  note_en,      0);
    tick();
    check("auto_en_edge2",  note_en,      1);
    check("auto_note0",     note_out,     5'h15);
    wait_idle("auto", 60);
    check("auto_rom_addr_end", bus.rom_addr, 6);

    // Learn play of song 1 with two wrong keys.
    push_note(5'h15, 8, 4, -1);
    push_note(5'h13, 4, 5, -1);
    push_done();
    pulse_start(3'd1, 1'b1);
    repeat (2) tick();
    check("learn_hint0",  hint_note, 5'h15);
    check("learn_en_off", note_en,   0);
    press(5'h10);
    press(5'h11);
    check("learn_miss2",  miss_cnt,  2);
    check("learn_hint_held", hint_note, 5'h15);
    press(5'h15);
    check("learn_en_on",  note_en,   1);
    repeat (8) tick();
    check("learn_en_end",   note_en,   0);
    check("learn_hint_clr", hint_note, 0);
    repeat (2) tick();
    check("learn_hint1",  hint_note, 5'h13);
    press(5'h13);
    wait_idle("learn", 40);
    check("learn_miss_kept", miss_cnt, 2);

    // Learn mode rest word: no key wait, 12 silent cycles then next fetch.
    pulse_start(3'd2, 1'b1);
    n = 0; saw_en = 0;
    while (hint_note == 5'd0 && n < 40) begin
      tick();
      n++;
      if (note_en) saw_en = 1;
    end
    check("rest_hint_latency", n,         16);
    check("rest_silent",       saw_en,    0);
    check("rest_hint",         hint_note, 5'h12);
    pulse_stop();
    check("stop_wk_busy", busy,      0);
    check("stop_wk_hint", hint_note, 0);
    check("stop_wk_done", done,      0);

    // Full song with no end marker: done after idx 3, no wrap.
    push_note(5'h0A, 4, 12, -1);
    push_note(5'h0B, 4, 13, 2);
    push_note(5'h0C, 4, 14, 2);
    push_note(5'h0D, 4, 15, 2);
    push_done();
    pulse_start(3'd3, 1'b0);
    wait_idle("full", 80);
    check("full_no_wrap", bus.rom_addr, 15);

    // Stop in the 3rd PLAY cycle.
    push_note(5'h15, 3, 4, -1);
    pulse_start(3'd1, 1'b0);
    repeat (4) tick();
    pulse_stop();
    check("stop_play_en",   note_en, 0);
    check("stop_play_busy", busy,    0);
    check("stop_play_done", done,    0);

    // start and stop together from IDLE.
    song_id = 3'd2; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    repeat (3) tick();
    check("startstop_busy_later", busy,         0);
    check("startstop_rom_addr",   bus.rom_addr, 4);

    // start while busy is ignored.
    push_note(5'h15, 8, 4, -1);
    push_note(5'h13, 4, 5, 2);
    push_done();
    pulse_start(3'd1, 1'b0);
    repeat (13) tick();
    check("busy_start_addr_before", bus.rom_addr, 5);
    pulse_start(3'd3, 1'b1);
    check("busy_start_addr_after", bus.rom_addr, 5);
    check("busy_start_busy",       busy,         1);
    wait_idle("busy_start", 40);
    check("busy_start_addr_end",   bus.rom_addr, 6);

    // miss_cnt saturation, held across stop, cleared on start.
    pulse_start(3'd1, 1'b1);
    repeat (2) tick();
    for (int i = 0; i < 260; i++) press(5'h01);
    check("miss_sat", miss_cnt, 255);
    pulse_stop();
    check("miss_held_stop", miss_cnt, 255);

    // rst in WAIT_KEY with miss_cnt = 5.
    pulse_start(3'd1, 1'b1);
    check("miss_clr_start", miss_cnt, 0);
    repeat (2) tick();
    for (int i = 0; i < 5; i++) press(5'h02);
    check("miss5", miss_cnt, 5);
    check("wk_hint_before_rst", hint_note, 5'h15);
    rst = 1'b1;
    tick();
    check("midrst_busy",     busy,         0);
    check("midrst_hint",     hint_note,    0);
    check("midrst_miss",     miss_cnt,     0);
    check("midrst_note_out", note_out,     0);
    check("midrst_note_en",  note_en,      0);
    check("midrst_done",     done,         0);
    check("midrst_rom_addr", bus.rom_addr, 0);
    rst = 1'b0;
    repeat (2) tick();

    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
